tqvp_text_buffer: RTL and testbench
===================================

TQVP_TEXT_BUFFER -- requirements
Module: tqvp_text_buffer

Interface
REQ-001 Parameter COLS, default 16, characters per row (2..64).
REQ-002 Parameter ROWS, default 6, rows of cells (2..32); cell count N = COLS*ROWS, 8 bits per cell.
REQ-003 clk  in  1  the only clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ui_in  in  8  ui_in[6:0] is the display read index; ui_in[7] is unused.
REQ-006 uo_out  out  8  display cell data.
REQ-007 address  in  6  register offset.
REQ-008 data_in  in  32  write data.
REQ-009 data_write_n  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
REQ-010 data_read_n  in  2  same encoding as data_write_n; it has no effect on behaviour.
REQ-011 data_out  out  32  read data, combinational from address.
REQ-012 data_ready  out  1  tied to 1.
REQ-013 user_interrupt  out  1  clear-done interrupt.

Function
REQ-014 Registers:
- 0x00 CHAR: write = put data_in[7:0] at the cursor; read = cell at the cursor, zero-extended.
- 0x04 CURSOR: [7:0] col, [15:8] row; read/write.
- 0x08 write: bit0 starts a full clear; bit1 clears the IRQ.
- 0x08 read STATUS: bit0 busy, bit1 irq, [15:8] top row.
- All other offsets: read 0, writes ignored.
REQ-015 Any write width hits the low byte; CURSOR row needs 16- or 32-bit writes.
REQ-016 Mapping: physical row = (logical row + top) mod ROWS; cell = physical row*COLS + col.
REQ-017 CHAR write of any byte except 0x0A:
- stores the byte and advances col;
- at col COLS-1, col becomes 0 and a newline step follows.
REQ-018 CHAR write of 0x0A stores nothing; col becomes 0 and a newline step follows.
REQ-019 Newline step: row < ROWS-1 gives row+1; row = ROWS-1 wraps row to 0 (see REQ-029 for scroll).
REQ-020 CURSOR write with col >= COLS or row >= ROWS is ignored entirely.
REQ-021 Clear engine writes 0x00 to one cell per cycle.
- Full clear takes N cycles and also zeroes the cursor and top.
- Row clear takes COLS cycles.
- busy is high from the cycle after the start through the last cell write.
REQ-022 While busy, CHAR and CURSOR writes and clear starts are ignored; reads still complete in one cycle.
REQ-023 Display port: uo_out is the cell at logical linear index ui_in[6:0], mapped through top, registered with 1-cycle latency.
- An index >= N outputs 0x00.
- uo_out reads 0x00 for cells not yet cleared after reset.
REQ-024 irq sets on the final cycle of a software-started full clear or a row clear.
- A 0x08 bit1 write clears it.
- If set and clear coincide, set wins.
- user_interrupt = irq.
REQ-025 The state machine has three states:
- IDLE to FULLCLR on a clear start or reset;
- IDLE to ROWCLR on a scroll;
- each returns to IDLE after its last cell.

Reset
REQ-026 When rst is high, set: cursor 0, top 0, irq 0, uo_out 0x00, state FULLCLR at cell 0.
REQ-027 After rst falls, the reset-started clear runs N cycles with busy=1 and does not raise irq.
REQ-028 rst asserted mid-clear restarts the full clear at cell 0.

Configuration
REQ-029 Macro TQVP_TEXTBUF_SCROLL_EN: when defined, a newline step at row ROWS-1 keeps row at ROWS-1, advances top by 1 (mod ROWS) and starts a row clear of the new bottom row.
- When undefined, the row wraps to 0, top stays 0 and the ROWCLR state is absent.

Structure
REQ-030 Package tqvp_textbuf_pkg holds the register offsets, STATUS bit positions, state encoding and the newline code 0x0A.
REQ-031 One sub-module tqvp_textbuf_mem: an N x 8 array with one write port and two read ports (CPU and display).

Verification
REQ-032 Release rst, then poll STATUS -> busy=1 for 96 cycles, then 0; irq=0; every CHAR read returns 0x00.
REQ-033 Write 16 CHAR bytes 0x41 from cursor (0,0) -> cursor reads 0x0100; display index 15 reads 0x41 one cycle later.
REQ-034 Cursor at (3,5), then write 0x0A:
- SCROLL_EN undefined -> cursor 0x0000, top 0;
- SCROLL_EN defined -> cursor 0x0500, top 1, busy for 16 cycles, irq=1.
REQ-035 Write 0x08 bit0, then write CHAR 0x55 during busy -> write ignored; irq=1 after 96 cycles; a 0x08 bit1 write coinciding with a completion leaves irq=1.
REQ-036 Write CURSOR 0x0010 (col 16) -> ignored, cursor unchanged; ui_in = 0x60 -> uo_out = 0x00.

Source files
------------

// File: rtl/tqvp_textbuf_pkg.sv
// Shared definitions for the text buffer: register map, STATUS/CTRL bit
// positions, write-width encoding, clear-engine states and newline code.
// Build option: TQVP_TEXTBUF_SCROLL_EN adds the ROWCLR state.
package tqvp_textbuf_pkg;

  localparam logic [5:0] REG_CHAR   = 6'h00;
  localparam logic [5:0] REG_CURSOR = 6'h04;
  localparam logic [5:0] REG_CTRL   = 6'h08;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_IRQ     = 1;
  localparam int STAT_TOP_LSB = 8;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_IRQCLR = 1;

  localparam logic [1:0] WR_8    = 2'b00;
  localparam logic [1:0] WR_16   = 2'b01;
  localparam logic [1:0] WR_32   = 2'b10;
  localparam logic [1:0] WR_NONE = 2'b11;

  localparam logic [7:0] CHAR_NL = 8'h0A;

`ifdef TQVP_TEXTBUF_SCROLL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_FULLCLR, ST_ROWCLR} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FULLCLR} state_e;
`endif

endpackage

// File: rtl/tqvp_text_buffer_if.sv
// Register bus between a host and the text buffer.
interface tqvp_text_buffer_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_textbuf_mem.sv
// Character cell store: one synchronous write port, two asynchronous
// read ports (CPU side and display side).
module tqvp_textbuf_mem #(
  parameter int N  = 96,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] craddr_i,
  output logic [7:0]    crdata_o,
  input  logic [AW-1:0] draddr_i,
  output logic [7:0]    drdata_o
);
  logic [7:0] mem_q [N];

  // Single write port shared by the CPU and the clear engine
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign crdata_o = mem_q[craddr_i];
  assign drdata_o = mem_q[draddr_i];
endmodule

// File: rtl/tqvp_text_buffer.sv
// Text buffer peripheral: COLS x ROWS character cells with a cursor,
// a display read port and a one-cell-per-cycle clear engine.
// Build option: TQVP_TEXTBUF_SCROLL_EN makes a newline on the bottom row
// scroll the window (advance top, clear the new bottom row) instead of
// wrapping the cursor to row 0.
module tqvp_text_buffer
  import tqvp_textbuf_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  tqvp_text_buffer_if.slave bus,
  output logic              user_interrupt
);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam logic [7:0]    COLS_B  = 8'(COLS);
  localparam logic [7:0]    ROWS_B  = 8'(ROWS);
  localparam logic [7:0]    COL_MAX = 8'(COLS - 1);
  localparam logic [7:0]    ROW_MAX = 8'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(N - 1);

  state_e        state_q;
  logic [AW-1:0] clr_idx_q;
  logic [AW-1:0] clr_last_q;
  logic          sw_clr_q;
  logic [7:0]    col_q;
  logic [7:0]    row_q;
  logic [7:0]    top_q;
  logic          irq_q;
  logic [7:0]    uo_q;

  logic          busy;
  logic          wr_en, wr_wide;
  logic          char_wr, cur_wr, clr_start, irq_clr, char_nl;
  logic [7:0]    char_byte, new_col, new_row;
  logic          clr_done;
  logic [AW-1:0] cur_addr, disp_addr;
  logic          disp_hit, cpu_pend, disp_pend;
  logic [7:0]    cpu_rd, disp_rd, disp_byte;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [31:0]   status_w;

  // Logical (row, col) to physical cell index, rotating rows by top
  function automatic logic [AW-1:0] cell_addr(input logic [7:0] lrow,
                                              input logic [7:0] col,
                                              input logic [7:0] top);
    int prow;
    prow = int'(lrow) + int'(top);
    if (prow >= ROWS) prow = prow - ROWS;
    return AW'(prow * COLS + int'(col));
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign wr_en     = (bus.data_write_n != WR_NONE);
  assign wr_wide   = (bus.data_write_n == WR_16) || (bus.data_write_n == WR_32);
  assign char_byte = bus.data_in[7:0];
  assign char_nl   = (char_byte == CHAR_NL);
  assign char_wr   = wr_en && (bus.address == REG_CHAR) && !busy;
  assign cur_wr    = wr_en && (bus.address == REG_CURSOR) && !busy;
  assign clr_start = wr_en && (bus.address == REG_CTRL) && bus.data_in[CTRL_CLR] && !busy;
  assign irq_clr   = wr_en && (bus.address == REG_CTRL) && bus.data_in[CTRL_IRQCLR];
  assign new_col   = bus.data_in[7:0];
  assign new_row   = wr_wide ? bus.data_in[15:8] : row_q;
  assign clr_done  = busy && (clr_idx_q == clr_last_q);
  assign cur_addr  = cell_addr(row_q, col_q, top_q);

  // Display index decode; out-of-range indices never touch the array
  always_comb begin
    int idx;
    idx       = int'(ui_in[6:0]);
    disp_hit  = (idx < N);
    disp_addr = '0;
    if (disp_hit) disp_addr = cell_addr(8'(idx / COLS), 8'(idx % COLS), top_q);
  end

  // Cells a running full clear has not reached yet read as zero
  assign cpu_pend  = (state_q == ST_FULLCLR) && (cur_addr >= clr_idx_q);
  assign disp_pend = (state_q == ST_FULLCLR) && (disp_addr >= clr_idx_q);
  assign disp_byte = (disp_hit && !disp_pend) ? disp_rd : 8'h00;

  // Write port arbitration: the clear engine owns the port while busy
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cur_addr;
    mem_wdata = char_byte;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = 8'h00;
    end else if (char_wr && !char_nl) begin
      mem_we = 1'b1;
    end
  end

  tqvp_textbuf_mem #(.N(N), .AW(AW)) u_mem (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .craddr_i (cur_addr),
    .crdata_o (cpu_rd),
    .draddr_i (disp_addr),
    .drdata_o (disp_rd)
  );

  // STATUS word assembly
  always_comb begin
    status_w                         = '0;
    status_w[STAT_BUSY]              = busy;
    status_w[STAT_IRQ]               = irq_q;
    status_w[STAT_TOP_LSB +: 8]      = top_q;
  end

  // Combinational register read mux
  always_comb begin
    bus.data_out = 32'h0;
    case (bus.address)
      REG_CHAR:   bus.data_out = {24'h0, (cpu_pend ? 8'h00 : cpu_rd)};
      REG_CURSOR: bus.data_out = {16'h0, row_q, col_q};
      REG_CTRL:   bus.data_out = status_w;
      default:    bus.data_out = 32'h0;
    endcase
  end

  // Clear-engine FSM, cursor/top bookkeeping, irq and display register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FULLCLR;
      clr_idx_q  <= '0;
      clr_last_q <= LAST_CELL;
      sw_clr_q   <= 1'b0;
      col_q      <= 8'h00;
      row_q      <= 8'h00;
      top_q      <= 8'h00;
      irq_q      <= 1'b0;
      uo_q       <= 8'h00;
    end else begin
      uo_q <= disp_byte;
      // Completion set takes priority over a same-cycle software clear
      if (irq_clr) irq_q <= 1'b0;
      if (clr_done && sw_clr_q) irq_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q    <= ST_FULLCLR;
            clr_idx_q  <= '0;
            clr_last_q <= LAST_CELL;
            sw_clr_q   <= 1'b1;
            col_q      <= 8'h00;
            row_q      <= 8'h00;
            top_q      <= 8'h00;
          end else if (cur_wr) begin
            if ((new_col < COLS_B) && (new_row < ROWS_B)) begin
              col_q <= new_col;
              row_q <= new_row;
            end
          end else if (char_wr) begin
            if (char_nl || (col_q == COL_MAX)) begin
              col_q <= 8'h00;
              if (row_q < ROW_MAX) begin
                row_q <= row_q + 8'd1;
              end else begin
`ifdef TQVP_TEXTBUF_SCROLL_EN
                // Old top row becomes the new bottom row and is wiped
                top_q      <= (top_q == ROW_MAX) ? 8'h00 : top_q + 8'd1;
                state_q    <= ST_ROWCLR;
                clr_idx_q  <= AW'(int'(top_q) * COLS);
                clr_last_q <= AW'(int'(top_q) * COLS + COLS - 1);
                sw_clr_q   <= 1'b1;
`else
                row_q <= 8'h00;
`endif
              end
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        default: begin
          if (clr_done) begin
            state_q  <= ST_IDLE;
            sw_clr_q <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + AW'(1);
          end
        end
      endcase
    end
  end

  assign uo_out         = uo_q;
  assign user_interrupt = irq_q;
  assign bus.data_ready = 1'b1;

  wire unused_ok = &{1'b0, bus.data_read_n, ui_in[7], bus.data_in[31:16]};
endmodule

// File: tb/tb_tqvp_text_buffer.sv
// Scoreboard bench for tqvp_text_buffer: stimulus pushes expected
// responses, a negedge monitor pops and compares when an output is due.
module tb_tqvp_text_buffer;
  import tqvp_textbuf_pkg::*;

  localparam int K_RD   = 0;
  localparam int K_DISP = 1;
  localparam int K_FLAG = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic       user_interrupt;
  logic       disp_req = 1'b0;
  logic       disp_vld = 1'b0;
  logic       flag_req = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  int          kind_q[$];
  string       name_q[$];

  tqvp_text_buffer_if bus_if();

  tqvp_text_buffer #(.COLS(16), .ROWS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus_if),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) disp_vld <= disp_req;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input int kind, input logic [31:0] got);
    logic [31:0] e;
    int          k;
    string       nm;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_output kind %0d: got %h, required no output", kind, got);
    end else begin
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      nm = name_q.pop_front();
      if (k != kind || got !== e) begin
        n_err++;
        $display("FAIL %s: got %h (kind %0d), required %h (kind %0d)", nm, got, kind, e, k);
      end
    end
  endtask

  // Monitor: compares whenever the DUT presents a response
  always @(negedge clk) begin
    if (bus_if.data_read_n != 2'b11) check(K_RD, bus_if.data_out);
    if (disp_vld)                    check(K_DISP, {24'h0, uo_out});
    if (flag_req)                    check(K_FLAG, {30'h0, bus_if.data_ready, user_interrupt});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(nm);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    bus_if.address      = a;
    bus_if.data_in      = d;
    bus_if.data_write_n = w;
    tick();
    bus_if.data_write_n = WR_NONE;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    push(K_RD, e, nm);
    bus_if.address     = a;
    bus_if.data_read_n = 2'b00;
    tick();
    bus_if.data_read_n = 2'b11;
  endtask

  task automatic disp(input logic [7:0] idx, input logic [7:0] e, input string nm);
    push(K_DISP, {24'h0, e}, nm);
    ui_in    = idx;
    disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    tick();
  endtask

  task automatic flags(input logic [1:0] e, input string nm);
    push(K_FLAG, {30'h0, e}, nm);
    flag_req = 1'b1;
    tick();
    flag_req = 1'b0;
  endtask

  initial begin
    bus_if.address      = 6'h00;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = WR_NONE;
    bus_if.data_read_n  = 2'b11;
    tick();
    tick();

    // Reset state while rst is held
    rd(REG_CURSOR, 32'h0, "rst_cursor");
    rd(REG_CTRL, 32'h1, "rst_status");
    flags(2'b10, "rst_flags");
    disp(8'd5, 8'h00, "rst_uo_out");

    // Reset-started clear: busy for 96 cycles, no irq
    rst = 1'b0;
    for (int i = 0; i < 96; i++) rd(REG_CTRL, 32'h1, $sformatf("init_busy_%0d", i));
    rd(REG_CTRL, 32'h0, "init_done_status");
    wr(REG_CURSOR, 32'h0000_0000, WR_32);
    rd(REG_CHAR, 32'h0, "init_char_0_0");
    wr(REG_CURSOR, 32'h0000_050F, WR_32);
    rd(REG_CHAR, 32'h0, "init_char_15_5");
    wr(REG_CURSOR, 32'h0000_0207, WR_32);
    rd(REG_CHAR, 32'h0, "init_char_7_2");

    // Fill row 0, cursor wraps to row 1
    wr(REG_CURSOR, 32'h0000_0000, WR_32);
    for (int i = 0; i < 16; i++) wr(REG_CHAR, 32'h0000_0041, WR_8);
    rd(REG_CURSOR, 32'h0000_0100, "fill_cursor");
    disp(8'd15, 8'h41, "fill_disp15");
    disp(8'd0, 8'h41, "fill_disp0");
    disp(8'd16, 8'h00, "fill_disp16");
    rd(REG_CHAR, 32'h0, "fill_char_1_0");

    // Write widths: 8-bit leaves row, 16-bit sets row
    wr(REG_CURSOR, 32'h0000_0702, WR_8);
    rd(REG_CURSOR, 32'h0000_0102, "cur_w8");
    wr(REG_CURSOR, 32'h0000_0401, WR_16);
    rd(REG_CURSOR, 32'h0000_0401, "cur_w16");

    // Newline on the bottom row
    wr(REG_CURSOR, 32'h0000_0503, WR_32);
    rd(REG_CURSOR, 32'h0000_0503, "nl_cursor_set");
    wr(REG_CHAR, 32'h0000_000A, WR_8);
`ifdef TQVP_TEXTBUF_SCROLL_EN
    for (int i = 0; i < 16; i++) rd(REG_CTRL, 32'h0000_0101, $sformatf("scroll_busy_%0d", i));
    rd(REG_CTRL, 32'h0000_0102, "scroll_done_status");
    rd(REG_CURSOR, 32'h0000_0500, "scroll_cursor");
    wr(REG_CTRL, 32'h2, WR_8);
    rd(REG_CTRL, 32'h0000_0100, "scroll_irq_cleared");
`else
    rd(REG_CURSOR, 32'h0000_0000, "nl_wrap_cursor");
    rd(REG_CTRL, 32'h0, "nl_wrap_status");
    disp(8'd83, 8'h00, "nl_not_stored");
`endif

    // Software full clear with writes ignored while busy
    wr(REG_CTRL, 32'h1, WR_8);
    wr(REG_CHAR, 32'h0000_0055, WR_8);
    wr(REG_CURSOR, 32'h0000_0203, WR_32);
    rd(REG_CTRL, 32'h1, "clr_busy_status");
    repeat (92) tick();
    wr(REG_CTRL, 32'h2, WR_8);
    rd(REG_CTRL, 32'h2, "clr_irq_set_wins");
    flags(2'b11, "clr_flags");
    rd(REG_CURSOR, 32'h0, "clr_cursor_kept");
    rd(REG_CHAR, 32'h0, "clr_char_ignored");
    disp(8'd15, 8'h00, "clr_disp15");
    wr(REG_CTRL, 32'h2, WR_8);
    rd(REG_CTRL, 32'h0, "irq_cleared");

    // Out-of-range cursor writes and display index bounds
    wr(REG_CURSOR, 32'h0000_0203, WR_32);
    rd(REG_CURSOR, 32'h0000_0203, "cur_valid");
    wr(REG_CURSOR, 32'h0000_0010, WR_32);
    rd(REG_CURSOR, 32'h0000_0203, "cur_col_oob");
    wr(REG_CURSOR, 32'h0000_0600, WR_32);
    rd(REG_CURSOR, 32'h0000_0203, "cur_row_oob");
    wr(REG_CURSOR, 32'h0000_0000, WR_32);
    wr(REG_CHAR, 32'h0000_0055, WR_8);
    rd(REG_CURSOR, 32'h0000_0001, "char_advance");
    disp(8'h00, 8'h55, "disp_cell0");
    disp(8'h60, 8'h00, "disp_idx_oob");
    disp(8'h80, 8'h55, "disp_bit7_ignored");
    rd(6'h0C, 32'h0, "rd_unmapped_0c");
    rd(6'h3C, 32'h0, "rd_unmapped_3c");

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
